// File: rtl/dvi_video_pkg.sv
// Shared definitions for DVI raster timing sources: FSM state codes,
// sync-level helpers and the default 640x480@60 timing set.
package dvi_video_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEEK = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 12;

  localparam logic        DEF_HS_POL     = 1'b0;
  localparam logic        DEF_VS_POL     = 1'b0;
  localparam logic [23:0] DEF_FILL_COLOR = 24'h000000;

  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

  function automatic logic idle_level(input logic pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/dvi_tx_video_timing_if.sv
// Pixel stream into the DVI timing generator: 24-bit RGB beats with a
// frame-start marker on a valid/ready handshake.
interface dvi_tx_video_timing_if;
  logic [23:0] s_data;
  logic        s_user;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_user, output s_valid, input s_ready);
  modport slave  (input s_data, input s_user, input s_valid, output s_ready);
endinterface

// File: rtl/dvi_tx_raster_counter.sv
// Free-running h/v raster counters with region decode. Decodes are
// combinational from the current count; the parent registers them.
module dvi_tx_raster_counter
  import dvi_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic advance,
  output logic h_act,
  output logic v_act,
  output logic hs,
  output logic vs,
  output logic first
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // NOTE: reset is synchronous, so it is just the highest-priority branch
  // of the clocked block; state updates use <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (advance) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

  assign h_act = (h_cnt < H_ACT_E);
  assign v_act = (v_cnt < V_ACT_E);
  assign hs    = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs    = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign first = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/dvi_tx_video_timing.sv
// DVI raster timing generator: aligns a framed pixel stream to the raster,
// falls back to FILL_COLOR and resynchronises on underflow/misalignment.
module dvi_tx_video_timing
  import dvi_video_pkg::*;
#(
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          H_FP       = DEF_H_FP,
  parameter int          H_SYNC     = DEF_H_SYNC,
  parameter int          H_BP       = DEF_H_BP,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter int          V_FP       = DEF_V_FP,
  parameter int          V_SYNC     = DEF_V_SYNC,
  parameter int          V_BP       = DEF_V_BP,
  parameter logic        HS_POL     = DEF_HS_POL,
  parameter logic        VS_POL     = DEF_VS_POL,
  parameter int          CNT_W      = DEF_CNT_W,
  parameter logic [23:0] FILL_COLOR = DEF_FILL_COLOR
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  dvi_tx_video_timing_if.slave         strm,
  output logic                         out_vsync,
  output logic                         out_hsync,
  output logic                         out_de,
  output logic [23:0]                  out_data,
  output logic [3:0]                   out_ctl,
  output logic                         frame_start,
  output logic                         underflow
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        h_act, v_act, hs, vs, first;
  logic        de;
  logic        sof_beat;
  logic        lock;
  logic        run_err;
  logic        ready;
  logic [23:0] pix_nxt;

  dvi_tx_raster_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CNT_W    (CNT_W)
  ) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!enable),
    .advance (state != ST_IDLE),
    .h_act   (h_act),
    .v_act   (v_act),
    .hs      (hs),
    .vs      (vs),
    .first   (first)
  );

  // NOTE: every signal assigned here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    de        = h_act && v_act;
    sof_beat  = strm.s_valid && strm.s_user;
    lock      = (state == ST_SEEK) && sof_beat && first;
    // A beat is good in RUN only when its frame marker matches the raster.
    run_err   = (state == ST_RUN) && de &&
                (!strm.s_valid || (strm.s_user != first));
    ready     = 1'b0;
    state_nxt = state;
    pix_nxt   = '0;

    case (state)
      ST_IDLE: state_nxt = ST_SEEK;
      ST_SEEK: begin
        ready = !sof_beat || first;
        if (lock) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // An early frame-start beat is left on the bus for the next SEEK.
        ready = de && !(sof_beat && !first);
        if (run_err) state_nxt = ST_SEEK;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (!enable)  state_nxt = ST_IDLE;
    if (!reset_n) ready     = 1'b0;

    if (de) begin
      if (lock || (state == ST_RUN && !run_err)) pix_nxt = strm.s_data;
      else                                        pix_nxt = FILL_COLOR;
    end
  end

  assign strm.s_ready = ready;
  assign out_ctl      = 4'b0000;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !enable || state == ST_IDLE) begin
      out_hsync   <= idle_level(HS_POL);
      out_vsync   <= idle_level(VS_POL);
      out_de      <= 1'b0;
      out_data    <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      out_hsync   <= sync_level(hs, HS_POL);
      out_vsync   <= sync_level(vs, VS_POL);
      out_de      <= de;
      out_data    <= pix_nxt;
      frame_start <= first;
      underflow   <= run_err;
    end
  end

endmodule

// File: doc/dvi_tx_video_timing.md
# dvi_tx_video_timing

Upstream stage of the DVI transmitter. Generates raster timing (hsync, vsync, data enable) from programmable porch/sync parameters and pulls 24-bit RGB pixels from a valid/ready stream with a frame-start marker. Its outputs drive the transmitter's vsync/hsync/de/data/ctl inputs directly, so the pipeline is stream source → this block → TMDS encode/serialize. It aligns the incoming stream to the raster and recovers from underflow or misalignment without breaking sync timing.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clk)
- H_SYNC, 96, hsync width (clk)
- H_BP, 48, horizontal back porch (clk)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level
- VS_POL, 0, vsync asserted level
- CNT_W, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FILL_COLOR, 24'h000000, pixel driven on active positions with no stream data

Ports:
- clk  in  1  pixel clock; same clock as the transmitter's `clk`
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  raster run enable
- s_data  in  24  pixel, {R,G,B} = [23:16],[15:8],[7:0]
- s_user  in  1  beat is first pixel of a frame
- s_valid  in  1  beat valid
- s_ready  out  1  beat accepted when s_valid && s_ready
- out_vsync  out  1  to transmitter vsync
- out_hsync  out  1  to transmitter hsync
- out_de  out  1  to transmitter data enable
- out_data  out  24  to transmitter pixel data
- out_ctl  out  4  constant 4'b0000
- frame_start  out  1  one-cycle pulse with output pixel (0,0)
- underflow  out  1  one-cycle pulse per error event

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- h_cnt wraps 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and wraps 0..V_TOTAL-1.
- Region order per axis: active, front porch, sync, back porch.
- h_act = h_cnt < H_ACTIVE. hs = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
- v_act and vs are decoded from v_cnt the same way. vsync transitions are therefore aligned to h_cnt==0.
- de = h_act && v_act. first = (h_cnt==0 && v_cnt==0).
- States:
  - IDLE: enable low; counters held at 0.
  - SEEK: s_ready = !(s_valid && s_user). Discards beats with s_user=0 and stalls on a frame-start beat. When that beat is present at first, transition to RUN and consume the beat at that position (s_ready=1).
  - RUN: s_ready = de.
- Error in RUN at a de position:
  - !s_valid is underflow.
  - s_valid && s_user && !first is early frame start; the beat is not consumed.
  - s_valid && !s_user && first is late frame start; the beat is consumed.
  - Response to any error: drive FILL_COLOR, pulse underflow, go to SEEK.
- In SEEK and IDLE, active positions drive FILL_COLOR and underflow stays 0.
- enable low at any time: IDLE at the next edge, counters cleared, outputs at idle levels. Resume restarts at (0,0) in SEEK.
- Idle levels: hsync = !HS_POL, vsync = !VS_POL, de = 0, data = 0.

## Timing
- All outputs except s_ready are registered, with one-cycle latency from counter position to pins. Data accepted in cycle N appears on out_data in cycle N+1 with out_de=1.
- s_ready is combinational from state, counters and s_valid/s_user. It is 0 in IDLE and during reset.
- Reset values: out_hsync = !HS_POL, out_vsync = !VS_POL, out_de = 0, out_data = 0, out_ctl = 0, frame_start = 0, underflow = 0, counters = 0, state = IDLE.
- Counters run freely in SEEK/RUN; stream errors never alter sync timing.
- After enable rises, the first (0,0) output occurs 2 cycles later (1 cycle to leave IDLE, 1 register stage).

## Structure
- Shared package/header `dvi_video_pkg` holds:
  - state encoding (IDLE/SEEK/RUN)
  - sync-level helpers
  - default 640x480@60 timing constants, reused by other timing sources
- Sub-module `dvi_tx_raster_counter` holds the h/v counters and region decode (h_act, v_act, hs, vs, first). The parent holds the FSM, stream handshake and output registers.

## Test plan
All scenarios use H 4/1/2/1 and V 3/1/1/1, giving H_TOTAL=8, V_TOTAL=6, 48 cycles per frame.
- Reset then enable, no stream → hsync low for h_cnt 5–6 of every line; vsync low for line 4; de never asserts pixel data other than FILL_COLOR; underflow stays 0; frame_start every 48 cycles.
- Continuous frames of 12 beats, s_user on beat 0, data = index → out_data 0..11 in order on the de cycles; frame_start aligned with pixel 0; no underflow.
- Stream starts with 5 junk beats, s_user=0 → junk dropped; s_ready stalls on the s_user beat until (0,0); frame outputs correctly.
- s_valid drops at pixel (2,1) in RUN → FILL_COLOR at that pixel; one underflow pulse; SEEK for the rest of the frame; clean frame next.
- s_user asserted at pixel 7 → beat not consumed; underflow pulse; it is consumed at the next (0,0).
- enable low mid-line, then high → outputs idle the next cycle; restart with frame_start 2 cycles after enable rises.
